// File: rtl/rv_imem_pkg.sv
// Shared constants and helpers for the instruction-memory controller.
package rv_imem_pkg;

  // RV32I canonical NOP (addi x0, x0, 0), returned on errored fetches and after reset.
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  localparam int unsigned DEPTH_DEF      = 1024;
  localparam int unsigned STARVE_MAX_DEF = 4;

  // Port-B owner for the current cycle.
  typedef enum logic [1:0] {
    PB_NONE,
    PB_FETCH,
    PB_DBG
  } pb_owner_e;

  // A fetch is in error when the PC is not word aligned or points past the RAM.
  function automatic logic fetch_addr_err(input logic [31:0] byte_addr,
                                          input int unsigned depth);
    return (byte_addr[1:0] != 2'b00) || ({2'b00, byte_addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/rv_imem_ctrl_if.sv
// Fetch, debug and RAM-side signals of the instruction-memory controller.
interface rv_imem_ctrl_if import rv_imem_pkg::*; #(
  parameter int AW = $clog2(DEPTH_DEF)
);

  logic          if_req_i;
  logic [31:0]   if_addr_i;
  logic          if_flush_i;
  logic          if_gnt_o;
  logic          if_rvalid_o;
  logic [31:0]   if_rdata_o;
  logic          if_err_o;

  logic          dbg_req_i;
  logic          dbg_we_i;
  logic [AW-1:0] dbg_addr_i;
  logic [31:0]   dbg_wdata_i;
  logic          dbg_gnt_o;
  logic          dbg_rvalid_o;
  logic [31:0]   dbg_rdata_o;

  logic          mem_wena_o;
  logic [AW-1:0] mem_addra_o;
  logic [31:0]   mem_dina_o;
  logic          mem_renb_o;
  logic [AW-1:0] mem_addrb_o;
  logic [31:0]   mem_doutb_i;

  // Controller side.
  modport slave (
    input  if_req_i, if_addr_i, if_flush_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
    input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    output dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
    output mem_wena_o, mem_addra_o, mem_dina_o, mem_renb_o, mem_addrb_o,
    input  mem_doutb_i
  );

  // Environment side: fetch stage, debug port and RAM.
  modport master (
    output if_req_i, if_addr_i, if_flush_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
    output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    input  dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
    input  mem_wena_o, mem_addra_o, mem_dina_o, mem_renb_o, mem_addrb_o,
    output mem_doutb_i
  );

endinterface

// File: rtl/rv_imem_arb.sv
// Port-B arbiter: debug reads win by default, a fetch that has lost
// STARVE_MAX consecutive contentions wins the next one.
module rv_imem_arb import rv_imem_pkg::*; #(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic fetch_vld_i,
  input  logic dbg_rd_i,
  input  logic coll_i,
  output logic fetch_gnt_o,
  output logic dbg_gnt_o
);

  localparam int CW = $clog2(STARVE_MAX + 2);

  logic [CW-1:0] starve_q, starve_d;
  logic          starved;

  assign starved = (starve_q >= CW'(STARVE_MAX));

  // Grant decision and starvation count for the next cycle.
  always_comb begin
    fetch_gnt_o = fetch_vld_i & ~coll_i & (~dbg_rd_i | starved);
    dbg_gnt_o   = dbg_rd_i & ~fetch_gnt_o;
    starve_d    = starve_q;
    if (!fetch_vld_i || fetch_gnt_o) begin
      starve_d = '0;
    end else if (dbg_gnt_o) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/rv_imem_ctrl.sv
// Instruction-RAM controller: debug writes on port A, fetch/debug reads
// arbitrated on the registered port B, errored fetches answered locally.
module rv_imem_ctrl import rv_imem_pkg::*; #(
  parameter int unsigned DEPTH      = DEPTH_DEF,
  parameter int          AW         = $clog2(DEPTH_DEF),
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input logic           clk,
  input logic           rst,
  rv_imem_ctrl_if.slave bus
);

  logic          addr_err;
  logic          err_req;
  logic          fetch_vld;
  logic          dbg_wr;
  logic          dbg_rd;
  logic          coll;
  logic          arb_fetch_gnt;
  logic          arb_dbg_gnt;
  logic [AW-1:0] if_word;
  logic [AW-1:0] addrb_q, addrb_d;
  pb_owner_e     pb_sel;

  logic          if_rvalid_q, if_err_q, if_rd_q;
  logic          dbg_rvalid_q;
  logic [31:0]   if_hold_q, dbg_hold_q;
  logic [31:0]   if_rdata, dbg_rdata;

  // Request qualification; everything is held off while reset is asserted.
  assign if_word   = bus.if_addr_i[AW+1:2];
  assign addr_err  = fetch_addr_err(bus.if_addr_i, DEPTH);
  assign err_req   = ~rst & bus.if_req_i & addr_err;
  assign fetch_vld = ~rst & bus.if_req_i & ~addr_err;
  assign dbg_wr    = ~rst & bus.dbg_req_i & bus.dbg_we_i;
  assign dbg_rd    = ~rst & bus.dbg_req_i & ~bus.dbg_we_i;
  // A fetch of the word being written this cycle waits, so it never sees stale data.
  assign coll      = fetch_vld & dbg_wr & (bus.dbg_addr_i == if_word);

  rv_imem_arb #(.STARVE_MAX(STARVE_MAX)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .fetch_vld_i (fetch_vld),
    .dbg_rd_i    (dbg_rd),
    .coll_i      (coll),
    .fetch_gnt_o (arb_fetch_gnt),
    .dbg_gnt_o   (arb_dbg_gnt)
  );

  // Port-B owner and address; the address holds when the port is idle.
  always_comb begin
    pb_sel  = PB_NONE;
    addrb_d = addrb_q;
    if (arb_fetch_gnt) begin
      pb_sel  = PB_FETCH;
      addrb_d = if_word;
    end else if (arb_dbg_gnt) begin
      pb_sel  = PB_DBG;
      addrb_d = bus.dbg_addr_i;
    end
  end

  assign bus.mem_renb_o  = (pb_sel != PB_NONE);
  assign bus.mem_addrb_o = addrb_d;

  assign bus.mem_wena_o  = dbg_wr;
  assign bus.mem_addra_o = bus.dbg_addr_i;
  assign bus.mem_dina_o  = bus.dbg_wdata_i;

  assign bus.if_gnt_o    = err_req | arb_fetch_gnt;
  assign bus.dbg_gnt_o   = dbg_wr | arb_dbg_gnt;

  // Read data comes straight from the RAM in the response cycle, else holds.
  assign if_rdata  = if_rd_q ? bus.mem_doutb_i : (if_err_q ? NOP_INSN : if_hold_q);
  assign dbg_rdata = dbg_rvalid_q ? bus.mem_doutb_i : dbg_hold_q;

  assign bus.if_rvalid_o  = if_rvalid_q;
  assign bus.if_err_o     = if_err_q;
  assign bus.if_rdata_o   = if_rdata;
  assign bus.dbg_rvalid_o = dbg_rvalid_q;
  assign bus.dbg_rdata_o  = dbg_rdata;

  // Response pipeline; a flush kills the response of the fetch granted alongside it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rvalid_q  <= 1'b0;
      if_err_q     <= 1'b0;
      if_rd_q      <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      if_hold_q    <= NOP_INSN;
      dbg_hold_q   <= '0;
      addrb_q      <= '0;
    end else begin
      if_rvalid_q  <= (err_req | arb_fetch_gnt) & ~bus.if_flush_i;
      if_err_q     <= err_req & ~bus.if_flush_i;
      if_rd_q      <= arb_fetch_gnt & ~bus.if_flush_i;
      dbg_rvalid_q <= arb_dbg_gnt;
      if_hold_q    <= if_rdata;
      dbg_hold_q   <= dbg_rdata;
      addrb_q      <= addrb_d;
    end
  end

endmodule

// File: tb/tb_rv_imem_ctrl.sv
// Self-checking bench for rv_imem_ctrl: behavioural model plus directed scenarios.
module tb_rv_imem_ctrl;

  localparam int          DEPTH = 1024;
  localparam int          AW    = 10;
  localparam int          SMAX  = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  rv_imem_ctrl_if #(.AW(AW)) bus ();

  rv_imem_ctrl #(.DEPTH(DEPTH), .AW(AW), .STARVE_MAX(SMAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // RAM fixture: write port A, registered read port B.
  logic [31:0] fram [DEPTH];
  logic [31:0] doutb_r = 32'h0;
  always @(posedge clk) begin
    if (bus.mem_wena_o) fram[bus.mem_addra_o] <= bus.mem_dina_o;
    if (bus.mem_renb_o) doutb_r <= fram[bus.mem_addrb_o];
  end
  assign bus.mem_doutb_i = doutb_r;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0]   mram [DEPTH];
  int            waits;
  logic          m_if_rv, m_if_err, m_dbg_rv;
  logic [31:0]   m_if_data, m_dbg_data;
  logic [AW-1:0] m_addrb;

  logic          e_err, e_fv, e_dwr, e_drd, e_coll, e_fgnt, e_dgnt, e_if_gnt, e_dbg_gnt;
  logic [AW-1:0] e_word, e_addrb;

  // What the controller must do this cycle, from the request rules.
  always_comb begin
    e_word    = bus.if_addr_i[AW+1:2];
    e_err     = 1'b0;
    e_fv      = 1'b0;
    e_dwr     = 1'b0;
    e_drd     = 1'b0;
    e_coll    = 1'b0;
    e_fgnt    = 1'b0;
    e_dgnt    = 1'b0;
    e_if_gnt  = 1'b0;
    e_dbg_gnt = 1'b0;
    e_addrb   = m_addrb;
    if (!rst) begin
      e_err     = bus.if_req_i && (((bus.if_addr_i % 4) != 0) || ((bus.if_addr_i / 4) >= DEPTH));
      e_fv      = bus.if_req_i && !e_err;
      e_dwr     = bus.dbg_req_i && bus.dbg_we_i;
      e_drd     = bus.dbg_req_i && !bus.dbg_we_i;
      e_coll    = e_fv && e_dwr && (bus.dbg_addr_i == e_word);
      e_fgnt    = e_fv && !e_coll && (!e_drd || waits >= SMAX);
      e_dgnt    = e_drd && !e_fgnt;
      e_if_gnt  = e_err || e_fgnt;
      e_dbg_gnt = e_dwr || e_dgnt;
      if (e_fgnt)      e_addrb = e_word;
      else if (e_dgnt) e_addrb = bus.dbg_addr_i;
    end
  end

  // Model state: responses due next cycle, shown data, starvation count, RAM contents.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      waits      <= 0;
      m_if_rv    <= 1'b0;
      m_if_err   <= 1'b0;
      m_if_data  <= NOP;
      m_dbg_rv   <= 1'b0;
      m_dbg_data <= 32'h0;
      m_addrb    <= '0;
    end else begin
      m_if_rv  <= e_if_gnt && !bus.if_flush_i;
      m_if_err <= e_err && !bus.if_flush_i;
      if (e_if_gnt && !bus.if_flush_i) m_if_data <= e_err ? NOP : mram[e_word];
      m_dbg_rv <= e_dgnt;
      if (e_dgnt) m_dbg_data <= mram[bus.dbg_addr_i];
      if (e_dwr) mram[bus.dbg_addr_i] <= bus.dbg_wdata_i;
      m_addrb <= e_addrb;
      if (!bus.if_req_i || e_if_gnt) waits <= 0;
      else if (e_dgnt)               waits <= waits + 1;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    chk1("if_gnt", bus.if_gnt_o, e_if_gnt);
    chk1("dbg_gnt", bus.dbg_gnt_o, e_dbg_gnt);
    chk1("mem_wena", bus.mem_wena_o, e_dwr);
    if (e_dwr) begin
      chk("mem_addra", 32'(bus.mem_addra_o), 32'(bus.dbg_addr_i));
      chk("mem_dina", bus.mem_dina_o, bus.dbg_wdata_i);
    end
    chk1("mem_renb", bus.mem_renb_o, e_fgnt || e_dgnt);
    chk("mem_addrb", 32'(bus.mem_addrb_o), 32'(e_addrb));
    chk1("if_rvalid", bus.if_rvalid_o, m_if_rv);
    chk1("if_err", bus.if_err_o, m_if_err);
    chk("if_rdata", bus.if_rdata_o, m_if_data);
    chk1("dbg_rvalid", bus.dbg_rvalid_o, m_dbg_rv);
    chk("dbg_rdata", bus.dbg_rdata_o, m_dbg_data);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    bus.if_req_i    = 1'b0;
    bus.if_addr_i   = 32'h0;
    bus.if_flush_i  = 1'b0;
    bus.dbg_req_i   = 1'b0;
    bus.dbg_we_i    = 1'b0;
    bus.dbg_addr_i  = '0;
    bus.dbg_wdata_i = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a);
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = a;
  endtask

  task automatic dbg(input logic we, input logic [AW-1:0] a, input logic [31:0] d);
    bus.dbg_req_i   = 1'b1;
    bus.dbg_we_i    = we;
    bus.dbg_addr_i  = a;
    bus.dbg_wdata_i = d;
  endtask

  logic [9:0] fpat, dpat;

  initial begin
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_if_rvalid", bus.if_rvalid_o, 1'b0);
    chk("rst_if_rdata", bus.if_rdata_o, 32'h0000_0013);
    chk("rst_dbg_rdata", bus.dbg_rdata_o, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Preload words 0..7 through debug writes.
    for (int i = 0; i < 8; i++) begin
      dbg(1'b1, AW'(i), 32'hC0DE_0000 + 32'(i));
      tick();
    end
    idle();
    tick();

    // Back-to-back fetches at 0x0, 0x4, 0x8.
    for (int k = 0; k < 4; k++) begin
      if (k < 3) fetch(32'(k * 4));
      else idle();
      @(negedge clk);
      if (k < 3) chk("b2b_addrb", 32'(bus.mem_addrb_o), 32'(k));
      if (k > 0) begin
        chk1("b2b_rvalid", bus.if_rvalid_o, 1'b1);
        chk("b2b_rdata", bus.if_rdata_o, 32'hC0DE_0000 + 32'(k - 1));
      end
      tick();
    end

    // Misaligned then out-of-range fetch.
    fetch(32'h0000_0002);
    @(negedge clk);
    chk1("mis_gnt", bus.if_gnt_o, 1'b1);
    chk1("mis_renb", bus.mem_renb_o, 1'b0);
    tick();
    fetch(32'h0000_1000);
    @(negedge clk);
    chk1("mis_rsp_err", bus.if_err_o, 1'b1);
    chk("mis_rsp_rdata", bus.if_rdata_o, 32'h0000_0013);
    chk1("oor_renb", bus.mem_renb_o, 1'b0);
    tick();
    idle();
    @(negedge clk);
    chk1("oor_rsp_rvalid", bus.if_rvalid_o, 1'b1);
    chk1("oor_rsp_err", bus.if_err_o, 1'b1);
    tick();

    // Debug read and fetch held together: 4 debug grants, then 1 fetch grant.
    for (int k = 0; k < 10; k++) begin
      fetch(32'h0000_0008);
      dbg(1'b0, AW'(3), 32'h0);
      @(negedge clk);
      fpat[k] = bus.if_gnt_o;
      dpat[k] = bus.dbg_gnt_o;
      tick();
    end
    chk("starve_fetch_pat", 32'(fpat), 32'(10'b1000010000));
    chk("starve_dbg_pat", 32'(dpat), 32'(10'b0111101111));
    idle();
    tick();

    // Debug write to word 5 while fetching 0x14.
    fetch(32'h0000_0014);
    dbg(1'b1, AW'(5), 32'hDEAD_BEEF);
    @(negedge clk);
    chk1("coll_if_gnt", bus.if_gnt_o, 1'b0);
    chk1("coll_dbg_gnt", bus.dbg_gnt_o, 1'b1);
    tick();
    bus.dbg_req_i = 1'b0;
    @(negedge clk);
    chk1("coll_retry_gnt", bus.if_gnt_o, 1'b1);
    tick();
    idle();
    @(negedge clk);
    chk1("coll_rvalid", bus.if_rvalid_o, 1'b1);
    chk("coll_rdata", bus.if_rdata_o, 32'hDEAD_BEEF);
    tick();

    // Flush with the fetch at N, new fetch at N+1.
    fetch(32'h0000_0004);
    bus.if_flush_i = 1'b1;
    @(negedge clk);
    chk1("flush_gnt", bus.if_gnt_o, 1'b1);
    tick();
    fetch(32'h0000_0008);
    bus.if_flush_i = 1'b0;
    @(negedge clk);
    chk1("flush_n1_rvalid", bus.if_rvalid_o, 1'b0);
    tick();
    idle();
    @(negedge clk);
    chk1("flush_n2_rvalid", bus.if_rvalid_o, 1'b1);
    chk("flush_n2_rdata", bus.if_rdata_o, 32'hC0DE_0002);
    tick();

    // Flushed errored fetch.
    fetch(32'h0000_0003);
    bus.if_flush_i = 1'b1;
    tick();
    idle();
    @(negedge clk);
    chk1("flush_err_rvalid", bus.if_rvalid_o, 1'b0);
    chk("flush_err_hold", bus.if_rdata_o, 32'hC0DE_0002);
    tick();

    // Errored fetch alongside a debug read: both served.
    fetch(32'h0000_1001);
    dbg(1'b0, AW'(1), 32'h0);
    @(negedge clk);
    chk1("errdbg_if_gnt", bus.if_gnt_o, 1'b1);
    chk1("errdbg_dbg_gnt", bus.dbg_gnt_o, 1'b1);
    tick();
    idle();
    @(negedge clk);
    chk("errdbg_dbg_rdata", bus.dbg_rdata_o, 32'hC0DE_0001);
    chk1("errdbg_if_err", bus.if_err_o, 1'b1);
    tick();

    // Reset right after a grant: response dropped, outputs reset at once.
    fetch(32'h0000_0000);
    @(negedge clk);
    chk1("rstmid_gnt", bus.if_gnt_o, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk1("rstmid_rvalid", bus.if_rvalid_o, 1'b0);
    chk("rstmid_rdata", bus.if_rdata_o, 32'h0000_0013);
    chk("rstmid_dbg_rdata", bus.dbg_rdata_o, 32'h0);
    dbg(1'b1, AW'(6), 32'h0000_1234);
    @(negedge clk);
    chk1("rstmid_wena", bus.mem_wena_o, 1'b0);
    tick();
    tick();
    idle();
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk1("post_rst_rvalid", bus.if_rvalid_o, 1'b0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
